// File: rtl/cp0_gen2.sv
// Coprocessor-0 (gen 2): SR/Cause/EPC/PRId/BadVAddr/Count/Compare with interrupt and exception arbitration.
// Latency: req and epc_out are combinational in the same cycle; register updates land on the next clk edge.
// Backpressure: none; a taken req discards a same-cycle mtc0 and overrides eret, because that instruction is flushed.
module cp0_gen2 #(
  parameter int          NUM_HWINT = 6,
  parameter bit          TIMER_EN  = 1'b1,
  parameter logic [31:0] PRID_VAL  = 32'h0000_7002
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [31:0]          vpc,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code_in,
  input  logic [31:0]          bad_vaddr_in,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 eret,
  output logic [31:0]          epc_out,
  output logic                 req,
  output logic                 timer_irq
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_SR       = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;

  // Architectural state
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic [5:0]  im_q,       im_d;
  logic        exl_q,      exl_d;
  logic        ie_q,       ie_d;
  logic        bd_q,       bd_d;
  logic        ti_q,       ti_d;
  logic [5:0]  ip_q,       ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q,      epc_d;

  logic [5:0]  int_vec;
  logic        int_req;
  logic        exc_req;
  logic        wr_ok;
  logic [31:0] vpc_adj;
  logic [31:0] epc_cap;

  // Build the live interrupt vector: external lines low-aligned, timer ORed into the top bit
  always_comb begin
    int_vec = '0;
    int_vec[NUM_HWINT-1:0] = hw_int;
    if (TIMER_EN) int_vec[5] = int_vec[5] | ti_q;
  end

  // Arbitrate interrupt vs exception; the EPC candidate backs up one word for delay-slot victims
  always_comb begin
    int_req = (|(int_vec & im_q)) & ie_q & ~exl_q;
    exc_req = (exc_code_in != 5'd0) & ~exl_q;
    req     = int_req | exc_req;
    vpc_adj = bd_in ? (vpc - 32'd4) : vpc;
    epc_cap = vpc_adj & 32'hFFFF_FFFC;
    epc_out = req ? epc_cap : epc_q;
    wr_ok   = we & ~req;
  end

  assign timer_irq = ti_q;

  // mfc0 read port: returns the registered (pre-write) value
  always_comb begin
    rdata = 32'd0;
    case (addr)
      A_BADVADDR: rdata = badvaddr_q;
      A_COUNT:    rdata = count_q;
      A_COMPARE:  rdata = compare_q;
      A_SR:       rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      A_CAUSE:    rdata = {bd_q, ti_q, 14'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      A_EPC:      rdata = epc_q;
      A_PRID:     rdata = PRID_VAL;
      default:    rdata = 32'd0;
    endcase
  end

  // Next-state: timer, mtc0, eret, then exception entry last so it wins every collision
  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_d       = int_vec;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (TIMER_EN) begin
      count_d = count_q + 32'd1;
      if (wr_ok && addr == A_COUNT) count_d = wdata;
      if (wr_ok && addr == A_COMPARE) begin
        compare_d = wdata;
        ti_d      = 1'b0;
      end else if (count_q == compare_q) begin
        ti_d = 1'b1;
      end
    end else begin
      count_d   = 32'd0;
      compare_d = 32'd0;
      ti_d      = 1'b0;
    end

    if (wr_ok && addr == A_SR) begin
      im_d  = wdata[15:10];
      exl_d = wdata[1];
      ie_d  = wdata[0];
    end
    if (wr_ok && addr == A_EPC) epc_d = wdata & 32'hFFFF_FFFC;

    // eret after the SR write so a combined mtc0 SR + eret still leaves EXL clear
    if (eret && !req) exl_d = 1'b0;

    if (req) begin
      exl_d      = 1'b1;
      bd_d       = bd_in;
      epc_d      = epc_cap;
      exc_code_d = int_req ? 5'd0 : exc_code_in;
      if (!int_req && (exc_code_in == 5'd4 || exc_code_in == 5'd5))
        badvaddr_d = bad_vaddr_in;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_gen2.sv
// Directed bench for cp0_gen2: default build plus a 2-line, timer-less build.
// Inputs are driven just after the falling edge; outputs are sampled before the next rising edge.
// All expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_cp0_gen2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [31:0] bad_vaddr_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic [31:0] epc_out;
  logic        req;
  logic        timer_irq;

  logic [4:0]  addr2;
  logic [31:0] rdata2;
  logic [1:0]  hw_int2;
  logic [31:0] epc_out2;
  logic        req2;
  logic        timer_irq2;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  cp0_gen2 u_dut (
    .clk(clk), .reset_n(reset_n), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .bad_vaddr_in(bad_vaddr_in),
    .hw_int(hw_int), .eret(eret), .epc_out(epc_out), .req(req), .timer_irq(timer_irq)
  );

  cp0_gen2 #(.NUM_HWINT(2), .TIMER_EN(1'b0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .we(1'b0), .addr(addr2), .wdata(32'd0), .rdata(rdata2),
    .vpc(32'd0), .bd_in(1'b0), .exc_code_in(5'd0), .bad_vaddr_in(32'd0),
    .hw_int(hw_int2), .eret(1'b0), .epc_out(epc_out2), .req(req2), .timer_irq(timer_irq2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0; vpc = 32'd0; bd_in = 1'b0;
    exc_code_in = 5'd0; bad_vaddr_in = 32'd0; hw_int = 6'd0; eret = 1'b0;
    addr2 = 5'd13; hw_int2 = 2'b10;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_timer_irq", {31'd0, timer_irq}, 32'd0);
    chk("rst_epc_out", epc_out, 32'd0);
    chk_reg("rst_prid", 5'd15, 32'h0000_7002);
    chk_reg("rst_sr", 5'd12, 32'd0);
    chk_reg("rst_cause", 5'd13, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("n2_cause_ip", rdata2, 32'h0000_0800);

    // Move Compare away so the post-reset Count==Compare hit is cleared
    mtc0(5'd11, 32'h0000_1000);

    // Interrupt with a simultaneous exception: interrupt priority, ExcCode 0, no BadVAddr capture
    mtc0(5'd12, 32'h0000_0401);
    chk_reg("sr_write", 5'd12, 32'h0000_0401);
    hw_int = 6'd1; vpc = 32'h0000_2000; exc_code_in = 5'd5; bad_vaddr_in = 32'h0000_DEAD;
    #1;
    chk("int_req", {31'd0, req}, 32'd1);
    chk("int_epc_out", epc_out, 32'h0000_2000);
    tick();
    exc_code_in = 5'd0;
    #1;
    chk("int_req_held_low", {31'd0, req}, 32'd0);
    chk_reg("int_sr_exl", 5'd12, 32'h0000_0403);
    chk_reg("int_cause", 5'd13, 32'h0000_0400);
    chk_reg("int_epc", 5'd14, 32'h0000_2000);
    chk_reg("int_badvaddr_kept", 5'd8, 32'd0);
    hw_int = 6'd0; eret = 1'b1;
    tick();
    eret = 1'b0;
    chk_reg("eret_sr", 5'd12, 32'h0000_0401);

    // AdEL in a delay slot
    exc_code_in = 5'd4; vpc = 32'h0000_3004; bd_in = 1'b1; bad_vaddr_in = 32'h0000_1235;
    #1;
    chk("adel_req", {31'd0, req}, 32'd1);
    chk("adel_epc_out", epc_out, 32'h0000_3000);
    tick();
    exc_code_in = 5'd0; bd_in = 1'b0;
    chk_reg("adel_epc", 5'd14, 32'h0000_3000);
    chk_reg("adel_cause", 5'd13, 32'h8000_0010);
    chk_reg("adel_badvaddr", 5'd8, 32'h0000_1235);
    exc_code_in = 5'd5;
    #1;
    chk("exc_masked_by_exl", {31'd0, req}, 32'd0);
    exc_code_in = 5'd0; eret = 1'b1;
    tick();
    eret = 1'b0;
    chk_reg("adel_eret_sr", 5'd12, 32'h0000_0401);

    // req beats mtc0 SR
    exc_code_in = 5'd12; vpc = 32'h0000_4000; we = 1'b1; addr = 5'd12; wdata = 32'd0;
    tick();
    we = 1'b0; exc_code_in = 5'd0;
    chk_reg("req_beats_we_sr", 5'd12, 32'h0000_0403);
    chk_reg("req_beats_we_cause", 5'd13, 32'h0000_0030);
    chk_reg("ov_badvaddr_kept", 5'd8, 32'h0000_1235);
    eret = 1'b1;
    tick();
    // req beats eret
    exc_code_in = 5'd10;
    tick();
    eret = 1'b0; exc_code_in = 5'd0;
    chk_reg("req_beats_eret", 5'd12, 32'h0000_0403);
    // eret with mtc0 SR: write applies, then EXL cleared
    eret = 1'b1;
    mtc0(5'd12, 32'h0000_0C03);
    eret = 1'b0;
    chk_reg("eret_with_sr_write", 5'd12, 32'h0000_0C01);

    // Timer: Compare=5, Count=0, IM7+IE
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    #1;
    chk("tmr_req_idle", {31'd0, req}, 32'd0);
    repeat (4) tick();
    chk_reg("tmr_count5", 5'd9, 32'd5);
    chk("tmr_ti_not_yet", {31'd0, timer_irq}, 32'd0);
    vpc = 32'h0000_5008;
    tick();
    chk("tmr_ti_set", {31'd0, timer_irq}, 32'd1);
    chk("tmr_req", {31'd0, req}, 32'd1);
    chk("tmr_epc_out", epc_out, 32'h0000_5008);
    tick();
    chk_reg("tmr_cause", 5'd13, 32'h4000_8000);
    chk("tmr_ti_sticky", {31'd0, timer_irq}, 32'd1);
    mtc0(5'd11, 32'h0000_0100);
    chk("tmr_ti_cleared", {31'd0, timer_irq}, 32'd0);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    chk_reg("count_max", 5'd9, 32'hFFFF_FFFF);
    tick();
    chk_reg("count_wrap", 5'd9, 32'd0);
    addr2 = 5'd9;
    #1;
    chk("n2_count_zero", rdata2, 32'd0);

    // Build EXL=1 and TI=1, then pulse reset mid-cycle
    mtc0(5'd12, 32'd0);
    exc_code_in = 5'd8; vpc = 32'h0000_6000;
    tick();
    exc_code_in = 5'd0;
    mtc0(5'd11, 32'h0000_0052);
    mtc0(5'd9, 32'h0000_0050);
    repeat (3) tick();
    chk("pre_rst_ti", {31'd0, timer_irq}, 32'd1);
    chk_reg("pre_rst_sr", 5'd12, 32'h0000_0002);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, req}, 32'd0);
    chk("arst_timer_irq", {31'd0, timer_irq}, 32'd0);
    chk("arst_epc_out", epc_out, 32'd0);
    chk_reg("arst_sr", 5'd12, 32'd0);
    chk_reg("arst_cause", 5'd13, 32'd0);
    chk_reg("arst_epc", 5'd14, 32'd0);
    chk_reg("arst_badvaddr", 5'd8, 32'd0);
    chk_reg("arst_count", 5'd9, 32'd0);
    chk_reg("arst_compare", 5'd11, 32'd0);
    chk_reg("arst_prid", 5'd15, 32'h0000_7002);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cp0_gen2.md
Name: cp0_gen2

Overview:
- Parametrised second-generation coprocessor-0 for the 5-stage MIPS pipeline; sits beside the M stage.
- Holds SR, Cause, EPC and PRId, and arbitrates interrupts and exceptions into a single `req` flush/redirect signal.
- New relative to the first generation: configurable hardware-interrupt width, a built-in Count/Compare timer interrupt, a BadVAddr register, an `eret` port, and defined same-cycle collision rules.

Parameters:
- NUM_HWINT, 6, number of external interrupt lines (1..6); mapped to IP bits 10 upward.
- TIMER_EN, 1, 1 = Count/Compare timer present; 0 = Count/Compare read 0 and the timer never fires.
- PRID_VAL, 32'h0000_7002, reset and constant value of PRId.

Ports:
- clk  in  1  clock (one clock).
- reset_n  in  1  reset; reset is asynchronous and active-low.
- we  in  1  mtc0 write enable.
- addr  in  5  CP0 register number for both read and write.
- wdata  in  32  mtc0 data.
- rdata  out  32  mfc0 data, combinational from `addr`.
- vpc  in  32  PC of the victim instruction.
- bd_in  in  1  victim instruction is in a delay slot.
- exc_code_in  in  5  exception code; 0 = none.
- bad_vaddr_in  in  32  faulting address for AdEL (4) / AdES (5).
- hw_int  in  NUM_HWINT  external interrupt levels.
- eret  in  1  eret at M stage; clears EXL.
- epc_out  out  32  redirect target: captured value when `req` = 1, else EPC.
- req  out  1  take exception/interrupt this cycle.
- timer_irq  out  1  mirror of Cause.TI.

Behaviour:
- Register map (any other addr reads 0; writes to it ignored):
  - 8 BadVAddr (RO)
  - 9 Count (RW)
  - 11 Compare (RW)
  - 12 SR: IM[15:10], EXL[1], IE[0]; other bits read 0
  - 13 Cause (RO): BD[31], TI[30], IP[15:10], ExcCode[6:2]
  - 14 EPC (RW, bits [1:0] forced 0)
  - 15 PRId (RO)
- Reset: all registers 0 except PRId = PRID_VAL. With idle inputs: `req` = 0, `timer_irq` = 0, `epc_out` = 0.
- Effective interrupt vector `int_vec[5:0]`:
  - `hw_int` zero-extended to 6 bits.
  - Bit 5 ORed with TI when TIMER_EN = 1.
- IP <= `int_vec` on every clock edge (1-cycle visibility lag for mfc0).
- `int_req` = |(`int_vec` & IM) & IE & !EXL. Uses the live `int_vec`, not IP.
- `exc_req` = (`exc_code_in` != 0) & !EXL.
- `req` = `int_req` | `exc_req`, combinational, same cycle.
- On a `req` edge:
  - EXL <= 1; BD <= `bd_in`.
  - EPC <= (`bd_in` ? `vpc` - 4 : `vpc`) with [1:0] forced 0.
  - ExcCode <= 0 if `int_req`, else `exc_code_in` (interrupt has priority).
  - BadVAddr <= `bad_vaddr_in` only if the exception path is taken and code is 4 or 5.
- Collision rules at one edge:
  - `req` beats `we`: mtc0 is discarded entirely, because the instruction is flushed.
  - `req` beats `eret`: EXL ends at 1.
  - `eret` with `we` to SR: the SR write applies first, then EXL is cleared.
- mfc0 read in the same cycle as a write returns the old value. No internal bypass; the pipeline forwards.
- Timer (TIMER_EN = 1):
  - Count += 1 every cycle; wraps 0xFFFF_FFFF -> 0.
  - mtc0 Count loads `wdata`; increment resumes the next cycle.
  - When current Count == Compare, TI <= 1 at the next edge. TI is sticky.
  - mtc0 Compare clears TI at that edge; clear beats set.
  - TI is cleared only by a Compare write or by reset.
- Reset asserted mid-operation: all state returns to reset values immediately (async). `req` drops once the inputs idle.

Test Plan:
- SR = 0x0000_0401, hw_int[0] = 1 -> `req` = 1 same cycle; next cycle Cause.ExcCode = 0, EXL = 1, IP[10] = 1, `req` = 0 while `hw_int` is held.
- `exc_code_in` = 4, `vpc` = 0x3004, `bd_in` = 1, `bad_vaddr_in` = 0x1235 -> EPC = 0x3000, BD = 1, BadVAddr = 0x1235, ExcCode = 4; then `eret` -> EXL = 0.
- Compare = 5, Count written 0, SR = 0x0000_8001 -> TI set on the edge after Count reaches 5, `timer_irq` = 1, `req` = 1; write Compare -> TI = 0.
- `req` and mtc0 SR = 0 in the same cycle -> SR.IE keeps its value and EXL = 1; `eret` + `req` together -> EXL = 1.
- Count written 0xFFFF_FFFF -> reads 0 two cycles later; NUM_HWINT = 2 build: hw_int = 2'b10 -> IP = 6'b000010.
- Async reset_n pulse mid-cycle with EXL = 1 and TI = 1 -> all registers 0, PRId = PRID_VAL, `req` = 0 before the next clk edge.
